// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath blocks: default byte width and the
// one-hot state encoding of the transmit buffer handshake FSM.
package uart_pkg;

  localparam int TXB_DATA_WIDTH = 8;
  localparam int TXB_STATE_W    = 3;

  typedef enum logic [TXB_STATE_W-1:0] {
    TXB_IDLE      = 3'b001,
    TXB_LOAD      = 3'b010,
    TXB_WAIT_DONE = 3'b100
  } txb_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; full/empty are decoded from the
// registered count so they carry no combinational path from the strobes.
module uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;

  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign push = wr_i && !full_o;
  assign pop  = rd_i && !empty_o;

  // Pointers are exactly ADDR_WIDTH bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO in front of the UART transmitter: hands one byte at a time to the
// transmitter with a start strobe and waits for its end-of-frame pulse.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = TXB_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy
);

  txb_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_rd;

  uart_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (i_wr),
    .wr_data_i(i_wr_data),
    .rd_i     (fifo_rd),
    .rd_data_o(fifo_rd_data),
    .full_o   (o_full),
    .empty_o  (o_empty),
    .count_o  (o_count)
  );

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TXB_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // A done pulse outside WAIT_DONE belongs to no frame of ours and is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TXB_IDLE:      if (!o_empty) state_d = TXB_LOAD;
      TXB_LOAD:      state_d = TXB_WAIT_DONE;
      TXB_WAIT_DONE: if (i_tx_done) state_d = TXB_IDLE;
      default:       state_d = TXB_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd    = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    overflow_d = overflow_q | (i_wr & o_full);
    case (state_q)
      TXB_LOAD: begin
        fifo_rd    = 1'b1;
        tx_data_d  = fifo_rd_data;
        tx_start_d = 1'b1;
        busy_d     = 1'b1;
      end
      TXB_WAIT_DONE: if (i_tx_done) busy_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer with a simple transmitter
// model that answers each start strobe with a done pulse after a set delay.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_wr = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       manualDone = 1'b0;
  logic       modelDone = 1'b0;
  logic       i_tx_done;
  logic       o_full, o_empty, o_overflow, o_tx_start, o_busy;
  logic [4:0] o_count;
  logic [7:0] o_tx_data;

  int         checkCount = 0;
  int         errorCount = 0;
  logic [7:0] startLog[$];
  bit         modelEn = 1'b0;
  int         modelDelay = 20;
  bit         prevStart = 1'b0;
  bit         prevBusy = 1'b0;
  logic [7:0] exp8;

  assign i_tx_done = manualDone | modelDone;

  uart_tx_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_count   (o_count),
    .o_overflow(o_overflow),
    .o_tx_start(o_tx_start),
    .o_tx_data (o_tx_data),
    .i_tx_done (i_tx_done),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    i_wr      = 1'b1;
    i_wr_data = b;
    tick();
    i_wr      = 1'b0;
  endtask

  task automatic waitDrained(input int expected, input int budget, input string tag);
    int n = 0;
    while (!(startLog.size() == expected && !o_busy && o_empty) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(n < budget), 1);
  endtask

  // Ends the current frame by hand and checks the next byte follows 3 cycles on.
  task automatic finishFrameExpectNext(input logic [7:0] expByte);
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    checkOutput("drainBusyLow", o_busy, 0);
    tick();
    checkOutput("drainGap", o_tx_start, 0);
    tick();
    checkOutput("drainStart", o_tx_start, 1);
    checkOutput("drainData", o_tx_data, expByte);
  endtask

  // Every start pulse is logged and must not follow a start or a busy cycle.
  initial forever begin
    tick();
    if (reset && o_tx_start) begin
      checkOutput("startAfterStart", prevStart, 0);
      checkOutput("startWhileBusy", prevBusy, 0);
      startLog.push_back(o_tx_data);
    end
    prevStart = o_tx_start;
    prevBusy  = o_busy;
  end

  initial forever begin
    tick();
    if (modelEn && reset && o_tx_start) begin
      logic [7:0] b;
      bit held;
      b    = o_tx_data;
      held = 1'b1;
      repeat (modelDelay - 1) begin
        tick();
        if (o_tx_data !== b || o_busy !== 1'b1) held = 1'b0;
      end
      modelDone = 1'b1;
      tick();
      modelDone = 1'b0;
      checkOutput("modelDataHeld", 32'(held), 1);
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: observed no completion, required finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) tick();
    checkOutput("rstEmpty", o_empty, 1);
    checkOutput("rstFull", o_full, 0);
    checkOutput("rstCount", o_count, 0);
    checkOutput("rstOverflow", o_overflow, 0);
    checkOutput("rstStart", o_tx_start, 0);
    checkOutput("rstData", o_tx_data, 0);
    checkOutput("rstBusy", o_busy, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Single byte hand-off and its latency
    startLog.delete();
    applyStimulus(8'hA5);
    checkOutput("a5CountK", o_count, 1);
    checkOutput("a5EmptyK", o_empty, 0);
    checkOutput("a5StartK", o_tx_start, 0);
    tick();
    checkOutput("a5StartK1", o_tx_start, 0);
    tick();
    checkOutput("a5StartK2", o_tx_start, 1);
    checkOutput("a5DataK2", o_tx_data, 8'hA5);
    checkOutput("a5BusyK2", o_busy, 1);
    checkOutput("a5CountK2", o_count, 0);
    tick();
    checkOutput("a5StartK3", o_tx_start, 0);
    checkOutput("a5BusyK3", o_busy, 1);
    checkOutput("a5DataK3", o_tx_data, 8'hA5);
    repeat (3) tick();
    checkOutput("a5BusyWait", o_busy, 1);
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    checkOutput("a5BusyDrop", o_busy, 0);
    checkOutput("a5StartCount", startLog.size(), 1);

    // Three back-to-back bytes through the transmitter model
    modelEn    = 1'b1;
    modelDelay = 5;
    startLog.delete();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    waitDrained(3, 200, "seqDrain");
    checkOutput("seqCount", startLog.size(), 3);
    for (int i = 0; i < startLog.size(); i++) checkOutput("seqByte", startLog[i], 32'(i + 1));
    modelEn = 1'b0;

    // Fill to full with the transmitter stalled, then overflow
    startLog.delete();
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i));
    checkOutput("fillCount15", o_count, 15);
    checkOutput("fillFull15", o_full, 0);
    checkOutput("fillBusy", o_busy, 1);
    checkOutput("fillStarts", startLog.size(), 1);
    if (startLog.size() > 0) checkOutput("fillFirstByte", startLog[0], 8'h10);
    applyStimulus(8'h20);
    checkOutput("fillCount16", o_count, 16);
    checkOutput("fillFull16", o_full, 1);
    checkOutput("fillNoOverflow", o_overflow, 0);
    applyStimulus(8'h21);
    checkOutput("ovfCount", o_count, 16);
    checkOutput("ovfFull", o_full, 1);
    checkOutput("ovfSet", o_overflow, 1);
    for (int i = 1; i <= 16; i++) begin
      exp8 = (i < 16) ? 8'(8'h10 + i) : 8'h20;
      finishFrameExpectNext(exp8);
    end
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    checkOutput("fillLastBusy", o_busy, 0);
    checkOutput("fillDrainedEmpty", o_empty, 1);
    checkOutput("ovfSticky", o_overflow, 1);
    checkOutput("fillStartTotal", startLog.size(), 17);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("ovfClearedByReset", o_overflow, 0);

    // Pointer wrap-around with bursts and a slow transmitter
    modelEn    = 1'b1;
    modelDelay = 20;
    startLog.delete();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 10; j++) applyStimulus(8'(b * 10 + j));
      repeat (230) tick();
    end
    waitDrained(40, 2000, "wrapDrain");
    checkOutput("wrapCount", startLog.size(), 40);
    for (int i = 0; i < startLog.size(); i++) checkOutput("wrapByte", startLog[i], 32'(i));
    checkOutput("wrapNoOverflow", o_overflow, 0);
    modelEn = 1'b0;

    // Spurious done pulses in IDLE and LOAD
    startLog.delete();
    manualDone = 1'b1;
    repeat (2) tick();
    checkOutput("spurIdleBusy", o_busy, 0);
    checkOutput("spurIdleStart", o_tx_start, 0);
    checkOutput("spurIdleCount", o_count, 0);
    applyStimulus(8'hB7);
    tick();
    tick();
    manualDone = 1'b0;
    checkOutput("spurStart", o_tx_start, 1);
    checkOutput("spurData", o_tx_data, 8'hB7);
    checkOutput("spurBusy", o_busy, 1);
    tick();
    checkOutput("spurStartLow", o_tx_start, 0);
    checkOutput("spurStillWaiting", o_busy, 1);
    repeat (4) tick();
    checkOutput("spurBusyHeld", o_busy, 1);
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    checkOutput("spurDoneBusy", o_busy, 0);
    repeat (5) tick();
    checkOutput("spurStartCount", startLog.size(), 1);

    // Asynchronous reset while waiting with bytes queued
    startLog.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h60 + i));
    tick();
    checkOutput("midCount", o_count, 5);
    checkOutput("midBusy", o_busy, 1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("asyncBusy", o_busy, 0);
    checkOutput("asyncStart", o_tx_start, 0);
    checkOutput("asyncData", o_tx_data, 0);
    checkOutput("asyncCount", o_count, 0);
    checkOutput("asyncEmpty", o_empty, 1);
    checkOutput("asyncFull", o_full, 0);
    checkOutput("asyncOverflow", o_overflow, 0);
    repeat (2) tick();
    reset = 1'b1;
    startLog.delete();
    repeat (20) tick();
    checkOutput("postRstNoStart", startLog.size(), 0);
    checkOutput("postRstBusy", o_busy, 0);
    checkOutput("postRstEmpty", o_empty, 1);
    applyStimulus(8'hC3);
    repeat (2) tick();
    checkOutput("postRstStart", o_tx_start, 1);
    checkOutput("postRstData", o_tx_data, 8'hC3);
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    checkOutput("postRstDone", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte-buffered front-end sitting directly upstream of the UART transmitter.
- Host logic pushes bytes into an internal FIFO at any rate.
- The block drains the FIFO one byte at a time: it presents the byte, pulses a start strobe into the transmitter, then waits for that transmitter's end-of-frame pulse before issuing the next byte.

Parameters:
- DATA_WIDTH, 8, byte width; must match the transmitter's DATA_WIDTH.
- ADDR_WIDTH, 4, FIFO address width; DEPTH = 2**ADDR_WIDTH (16 entries).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_wr  input  1  push strobe, one byte per cycle when high.
- i_wr_data  input  DATA_WIDTH  byte to push.
- o_full  output  1  FIFO holds DEPTH entries.
- o_empty  output  1  FIFO holds 0 entries.
- o_count  output  ADDR_WIDTH+1  current FIFO occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a push was attempted while full.
- o_tx_start  output  1  one-cycle start pulse to the transmitter's start input.
- o_tx_data  output  DATA_WIDTH  byte for the transmitter; held stable from o_tx_start until i_tx_done.
- i_tx_done  input  1  end-of-frame pulse from the transmitter.
- o_busy  output  1  high while a byte is handed off and not yet done.

Behaviour:
- Reset (async assert, sync release): pointers and count = 0, o_empty=1, o_full=0, o_overflow=0, o_tx_start=0, o_tx_data=0, o_busy=0, state=IDLE.
- All outputs are registered, or decoded from registered count only.
- Push: accepted iff i_wr=1 and count<DEPTH at the start of the cycle.
  - Data is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Push while full: the data is dropped, count is unchanged, and o_overflow sets. It stays set until reset, even if a pop occurs in the same cycle.
- Pop: internal only, issued by the FSM. rd_ptr wraps modulo DEPTH.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- FSM states use one-hot encoding: IDLE=3'b001, LOAD=3'b010, WAIT_DONE=3'b100.
  - IDLE: if count!=0, go to LOAD; else stay.
  - LOAD (one cycle): register o_tx_data <= mem[rd_ptr], pop, set o_tx_start=1 and o_busy=1 for the next cycle, then go to WAIT_DONE.
  - WAIT_DONE: o_tx_start=0, o_tx_data and o_busy held. On i_tx_done=1, go to IDLE with o_busy=0 next cycle.
  - An i_tx_done seen in IDLE or LOAD is ignored.
- Latency:
  - Push into an empty, idle buffer at edge k: count=1 after k, LOAD after k+1, o_tx_start high for the cycle after edge k+2.
  - After i_tx_done with data pending: the next o_tx_start pulse follows 3 cycles later. This guarantees the transmitter is back in its idle state before the strobe.
- o_tx_start is never high for more than one cycle and never high while o_busy was already 1.
- No timeout: if i_tx_done never arrives, the block waits in WAIT_DONE indefinitely. Pushes continue to be accepted until full.
- Reset mid-frame: the buffer discards queued data and the in-flight byte. The transmitter's own reset is the system integrator's responsibility.

Decomposition:
- Shared package uart_pkg:
  - state localparams TXB_IDLE, TXB_LOAD, TXB_WAIT_DONE;
  - default DATA_WIDTH;
  - one-hot state width constant.
- One sub-module: uart_fifo, a synchronous FIFO with wr/rd strobes, full, empty, count and a registered or array read. It is reusable by the future receive path.
- The FSM and handshake stay in uart_tx_buffer.

Test Plan:
- Reset, then a single push of 8'hA5 at edge k: o_tx_start pulses for exactly one cycle after edge k+2 with o_tx_data=8'hA5 and o_busy=1. o_count returns to 0. o_busy drops the cycle after i_tx_done.
- Push 8'h01, 8'h02, 8'h03 back-to-back: three o_tx_start pulses in order 01, 02, 03. Each pulse waits for the prior i_tx_done. o_tx_data holds steady between start and done.
- Fill: 16 pushes with i_tx_done held off. o_full=1 and o_count=16 after the first byte is popped and the 17th push lands. An 18th push is dropped, o_overflow=1, and the queued bytes are unchanged.
- Wrap-around: 40 bytes 0..39 pushed in bursts of 10 with a transmitter model that responds after 20 cycles. All 40 are emitted in order and o_overflow stays 0.
- Spurious i_tx_done pulses in IDLE and LOAD: no state change and no extra o_tx_start.
- Assert reset in WAIT_DONE with 5 bytes queued: all outputs take reset values immediately (asynchronously). After release, no o_tx_start occurs until a new push.
